// File: rtl/nios_led_driver.sv
// Avalon-MM LED/GPIO output driver with per-bit blink engine.
// Blink phase toggles every PERIOD clocks and raises a sticky TICK.
module nios_led_driver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_BLINK  = 3'd1;
   localparam logic [2:0] A_PERIOD = 3'd2;
   localparam logic [2:0] A_STATUS = 3'd3;
   localparam logic [2:0] A_OUTSET = 3'd4;
   localparam logic [2:0] A_OUTCLR = 3'd5;

   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] blink_en;
   logic [23:0]      period;
   logic [23:0]      cnt;
   logic             phase;
   logic             tick;
   logic             irq_en;

   logic             wr_en;
   logic             wr_data;
   logic             wr_blink;
   logic             wr_period;
   logic             wr_status;
   logic             wr_set;
   logic             wr_clr;
   logic             tick_evt;
   logic [WIDTH-1:0] wd_field;
   logic [23:0]      wd_period;
   logic [31:0]      rd_mux;

   assign wr_en     = chipselect & ~write_n;
   assign wr_data   = wr_en && (address == A_DATA);
   assign wr_blink  = wr_en && (address == A_BLINK);
   assign wr_period = wr_en && (address == A_PERIOD);
   assign wr_status = wr_en && (address == A_STATUS);
   assign wr_set    = wr_en && (address == A_OUTSET);
   assign wr_clr    = wr_en && (address == A_OUTCLR);

   assign wd_field  = writedata[WIDTH-1:0];
   assign wd_period = writedata[23:0];

   // A PERIOD write restarts the engine, so it suppresses the tick.
   assign tick_evt  = (period != 24'd0) && (cnt == 24'd0) && !wr_period;

   assign irq = tick & irq_en;

   always_comb begin
      rd_mux = 32'd0;
      case (address)
         A_DATA:   rd_mux = 32'(data);
         A_BLINK:  rd_mux = 32'(blink_en);
         A_PERIOD: rd_mux = {8'd0, period};
         A_STATUS: rd_mux = {30'd0, irq_en, tick};
         default:  rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data     <= '0;
         blink_en <= '0;
      end else begin
         if (wr_data)
            data <= wd_field;
         else if (wr_set)
            data <= data | wd_field;
         else if (wr_clr)
            data <= data & ~wd_field;
         if (wr_blink)
            blink_en <= wd_field;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period <= 24'd0;
         cnt    <= 24'd0;
         phase  <= 1'b0;
      end else if (wr_period) begin
         period <= wd_period;
         cnt    <= (wd_period == 24'd0) ? 24'd0 : wd_period - 24'd1;
         phase  <= 1'b0;
      end else if (period == 24'd0) begin
         cnt    <= 24'd0;
         phase  <= 1'b0;
      end else if (cnt == 24'd0) begin
         cnt    <= period - 24'd1;
         phase  <= ~phase;
      end else begin
         cnt    <= cnt - 24'd1;
      end
   end

   // Set beats a same-edge STATUS write clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick   <= 1'b0;
         irq_en <= 1'b0;
      end else begin
         if (wr_status)
            irq_en <= writedata[1];
         if (tick_evt)
            tick <= 1'b1;
         else if (wr_status)
            tick <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= 32'd0;
         out_port <= '0;
      end else begin
         readdata <= rd_mux;
         out_port <= data ^ (blink_en & {WIDTH{phase}});
      end
   end

endmodule

// File: tb/tb_nios_led_driver.sv
// Directed self-checking bench for nios_led_driver.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_nios_led_driver;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;
   logic        irq;

   int checks = 0;
   int errors = 0;

   nios_led_driver #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a falling edge; write lands on the next rising edge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      #2;
      checks++;
      if (out_port !== 8'h00 || readdata !== 32'd0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_outs got out=%h rd=%h irq=%b exp 00/0/0",
                  out_port, readdata, irq);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd(3'd0, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL reset_data got %h exp 0", v);
      end
      rd(3'd3, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL reset_status got %h exp 0", v);
      end
   endtask

   task automatic test_data;
      wr(3'd0, 32'h0000_00A5);
      checks++;
      if (out_port !== 8'h00) begin
         errors++;
         $display("FAIL data_lat got %h exp 00", out_port);
      end
      @(negedge clk);
      checks++;
      if (out_port !== 8'hA5) begin
         errors++;
         $display("FAIL data_out got %h exp a5", out_port);
      end
      checks++;
      if (readdata !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL data_rd got %h exp 000000a5", readdata);
      end
   endtask

   task automatic test_setclr;
      logic [31:0] v;
      wr(3'd4, 32'h0000_000F);
      @(negedge clk);
      checks++;
      if (out_port !== 8'hAF) begin
         errors++;
         $display("FAIL outset_out got %h exp af", out_port);
      end
      checks++;
      if (readdata !== 32'd0) begin
         errors++;
         $display("FAIL rd_addr4 got %h exp 0", readdata);
      end
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_00AF) begin
         errors++;
         $display("FAIL outset_rd got %h exp af", v);
      end
      wr(3'd5, 32'h0000_0081);
      @(negedge clk);
      checks++;
      if (out_port !== 8'h2E) begin
         errors++;
         $display("FAIL outclr_out got %h exp 2e", out_port);
      end
      wr(3'd6, 32'h0000_00FF);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_002E) begin
         errors++;
         $display("FAIL outclr_rd got %h exp 2e", v);
      end
      rd(3'd7, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL rd_addr7 got %h exp 0", v);
      end
      wr(3'd1, 32'hFFFF_FF00);
      rd(3'd1, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL blink_upper got %h exp 0", v);
      end
      wr(3'd2, 32'hFF00_0000);
      rd(3'd2, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL period_upper got %h exp 0", v);
      end
   endtask

   task automatic test_blink;
      logic [7:0]  exp_o;
      logic [31:0] exp_s;
      wr(3'd0, 32'd0);
      wr(3'd1, 32'h0000_0003);
      wr(3'd2, 32'd4);
      address = 3'd3;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp_o = (((k - 1) / 4) % 2 == 1) ? 8'h03 : 8'h00;
         exp_s = (k >= 5) ? 32'd1 : 32'd0;
         checks++;
         if (out_port !== exp_o || readdata !== exp_s) begin
            errors++;
            $display("FAIL blink_k%0d got out=%h st=%h exp out=%h st=%h",
                     k, out_port, readdata, exp_o, exp_s);
         end
      end
   endtask

   task automatic test_irq;
      wr(3'd2, 32'd4);
      wr(3'd3, 32'h0000_0002);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clr got %b exp 0", irq);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_early got %b exp 0", irq);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_rise got %b exp 1", irq);
      end
      wr(3'd3, 32'h0000_0002);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_ack got %b exp 0", irq);
      end
      @(negedge clk);
      checks++;
      if (readdata !== 32'd2) begin
         errors++;
         $display("FAIL irq_en_kept got %h exp 2", readdata);
      end
      @(negedge clk);
      wr(3'd3, 32'h0000_0002);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_setwins got %b exp 1", irq);
      end
      @(negedge clk);
      checks++;
      if (readdata !== 32'd3) begin
         errors++;
         $display("FAIL status_setwins got %h exp 3", readdata);
      end
      wr(3'd3, 32'd0);
   endtask

   task automatic test_period_zero;
      logic [31:0] v;
      wr(3'd2, 32'd3);
      repeat (4) @(negedge clk);
      checks++;
      if (out_port !== 8'h03) begin
         errors++;
         $display("FAIL p3_phase got %h exp 03", out_port);
      end
      wr(3'd2, 32'd0);
      checks++;
      if (out_port !== 8'h03) begin
         errors++;
         $display("FAIL p0_lat got %h exp 03", out_port);
      end
      wr(3'd3, 32'd0);
      checks++;
      if (out_port !== 8'h00) begin
         errors++;
         $display("FAIL p0_out got %h exp 00", out_port);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (out_port !== 8'h00) begin
            errors++;
            $display("FAIL p0_hold%0d got %h exp 00", k, out_port);
         end
      end
      rd(3'd3, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL p0_notick got %h exp 0", v);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] v;
      wr(3'd0, 32'h0000_00FF);
      wr(3'd3, 32'h0000_0002);
      wr(3'd2, 32'd2);
      address = 3'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (irq !== 1'b1 || readdata !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL mid_pre got irq=%b rd=%h exp 1/ff", irq, readdata);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_port !== 8'h00 || readdata !== 32'd0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst got out=%h rd=%h irq=%b exp 00/0/0",
                  out_port, readdata, irq);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (out_port !== 8'h00) begin
            errors++;
            $display("FAIL mid_hold%0d got %h exp 00", k, out_port);
         end
      end
      rd(3'd2, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL mid_period got %h exp 0", v);
      end
   endtask

   initial begin
      test_reset();
      test_data();
      test_setclr();
      test_blink();
      test_irq();
      test_period_zero();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
